// File: rtl/padlock_pkg.sv
// Shared constants, FSM state encoding and digit extraction for the padlock code sender.
package padlock_pkg;

    localparam int DIGIT_W  = 2;
    localparam int CODE_LEN = 4;
    localparam int CODE_W   = DIGIT_W * CODE_LEN;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_PRESS = 3'd1,
        S_GAP   = 3'd2,
        S_OPEN  = 3'd3,
        S_WAIT  = 3'd4,
        S_CHECK = 3'd5,
        S_DONE  = 3'd6
    } state_t;

    // Digit k of a code lives in bits [2k+1:2k]; digit 0 is entered first.
    function automatic logic [DIGIT_W-1:0] digit_of(input logic [CODE_W-1:0] code,
                                                    input logic [1:0]        idx);
        digit_of = code[{idx, 1'b0} +: DIGIT_W];
    endfunction

endpackage

// File: rtl/padlock_key_pulse.sv
// Registered 2-bit digit to one-hot key pulse decoder; all keys low when not valid.
module padlock_key_pulse
    import padlock_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               valid,
    input  logic [DIGIT_W-1:0] digit,
    output logic [3:0]         keys
);

    // One-hot key register, cleared on every cycle without a valid digit.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            keys <= 4'b0000;
        end else if (valid) begin
            case (digit)
                2'd0:    keys <= 4'b0001;
                2'd1:    keys <= 4'b0010;
                2'd2:    keys <= 4'b0100;
                2'd3:    keys <= 4'b1000;
                default: keys <= 4'b0000;
            endcase
        end else begin
            keys <= 4'b0000;
        end
    end

endmodule

// File: rtl/padlock_code_sender.sv
// Sends 4-digit codes to a padlock as button pulses, pulses open and samples lock;
// replays one code or sweeps 0x00..0xFF until the lock opens.
module padlock_code_sender
    import padlock_pkg::*;
#(
    parameter int unsigned GAP_CYCLES  = 2,
    parameter int unsigned RESP_CYCLES = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              sweep,
    input  logic [CODE_W-1:0] code,
    output logic              busy,
    output logic              done,
    output logic              success,
    output logic [CODE_W-1:0] found_code,
    output logic              but_0,
    output logic              but_1,
    output logic              but_2,
    output logic              but_3,
    output logic              open,
    input  logic              lock
);

    localparam logic [3:0]        GAP_LAST  = 4'(GAP_CYCLES - 32'd1);
    localparam logic [2:0]        RESP_LAST = 3'(RESP_CYCLES - 32'd1);
    localparam logic [1:0]        IDX_LAST  = 2'(CODE_LEN - 1);
    localparam logic [CODE_W-1:0] CODE_MAX  = 8'hFF;
    localparam bit                NO_GAP    = (GAP_CYCLES == 32'd0);

    state_t              state;
    logic [1:0]          idx;
    logic [3:0]          gap_cnt;
    logic [2:0]          resp_cnt;
    logic [CODE_W-1:0]   cur;
    logic                sweep_mode;
    logic                lock_smp;
    logic                key_valid;
    logic [DIGIT_W-1:0]  key_digit;
    logic [3:0]          keys;
    logic                gap_end;
    logic                retry;

    assign gap_end = (state == S_GAP) && (gap_cnt == GAP_LAST);
    assign retry   = lock_smp && sweep_mode && (cur != CODE_MAX);

    // The decoder registers its input, so it is fed the press that the FSM enters
    // on this edge; that keeps each button pulse aligned with its PRESS cycle.
    always_comb begin
        key_valid = 1'b0;
        key_digit = 2'd0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    key_valid = 1'b1;
                    key_digit = digit_of(sweep ? 8'h00 : code, 2'd0);
                end else begin
                    key_valid = 1'b0;
                    key_digit = 2'd0;
                end
            end
            S_PRESS, S_GAP: begin
                if ((NO_GAP || gap_end) && (idx != IDX_LAST)) begin
                    key_valid = 1'b1;
                    key_digit = digit_of(cur, idx + 2'd1);
                end else begin
                    key_valid = 1'b0;
                    key_digit = 2'd0;
                end
            end
            S_CHECK: begin
                if (retry) begin
                    key_valid = 1'b1;
                    key_digit = digit_of(cur + 8'd1, 2'd0);
                end else begin
                    key_valid = 1'b0;
                    key_digit = 2'd0;
                end
            end
            default: begin
                key_valid = 1'b0;
                key_digit = 2'd0;
            end
        endcase
    end

    padlock_key_pulse u_key_pulse (
        .clk   (clk),
        .reset (reset),
        .valid (key_valid),
        .digit (key_digit),
        .keys  (keys)
    );

    assign but_0 = keys[0];
    assign but_1 = keys[1];
    assign but_2 = keys[2];
    assign but_3 = keys[3];

    // Sequencing FSM with its registered status outputs and the open pulse.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= S_IDLE;
            idx        <= 2'd0;
            gap_cnt    <= 4'd0;
            resp_cnt   <= 3'd0;
            cur        <= 8'h00;
            sweep_mode <= 1'b0;
            lock_smp   <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            success    <= 1'b0;
            found_code <= 8'h00;
            open       <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        cur        <= sweep ? 8'h00 : code;
                        sweep_mode <= sweep;
                        success    <= 1'b0;
                        found_code <= 8'h00;
                        busy       <= 1'b1;
                        idx        <= 2'd0;
                        state      <= S_PRESS;
                    end
                end
                S_PRESS: begin
                    gap_cnt <= 4'd0;
                    if (!NO_GAP) begin
                        state <= S_GAP;
                    end else if (idx != IDX_LAST) begin
                        idx   <= idx + 2'd1;
                        state <= S_PRESS;
                    end else begin
                        open  <= 1'b1;
                        state <= S_OPEN;
                    end
                end
                S_GAP: begin
                    if (gap_end) begin
                        gap_cnt <= 4'd0;
                        if (idx != IDX_LAST) begin
                            idx   <= idx + 2'd1;
                            state <= S_PRESS;
                        end else begin
                            open  <= 1'b1;
                            state <= S_OPEN;
                        end
                    end else begin
                        gap_cnt <= gap_cnt + 4'd1;
                    end
                end
                S_OPEN: begin
                    open     <= 1'b0;
                    resp_cnt <= 3'd0;
                    state    <= S_WAIT;
                end
                S_WAIT: begin
                    if (resp_cnt == RESP_LAST) begin
                        lock_smp <= lock;
                        state    <= S_CHECK;
                    end else begin
                        resp_cnt <= resp_cnt + 3'd1;
                    end
                end
                S_CHECK: begin
                    found_code <= cur;
                    if (retry) begin
                        cur   <= cur + 8'd1;
                        idx   <= 2'd0;
                        state <= S_PRESS;
                    end else begin
                        success <= ~lock_smp;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        state   <= S_DONE;
                    end
                end
                S_DONE: begin
                    done  <= 1'b0;
                    state <= S_IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    open  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_padlock_code_sender.sv
// Directed bench: two sender instances (default timing and GAP=0/RESP=3) each driving a padlock model.
module tb_padlock_code_sender;

    typedef struct {
        logic       success;
        logic [7:0] code;
        int         opens;
    } exp_t;

    logic clk = 1'b0;
    int   cyc = 0;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input int inst, input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL dut%0d %s: observed %0d expected %0d", inst, tag, obs, exp);
        end
    endtask

    function automatic logic [1:0] onehot_dig(input logic [3:0] k);
        case (k)
            4'b0010: onehot_dig = 2'd1;
            4'b0100: onehot_dig = 2'd2;
            4'b1000: onehot_dig = 2'd3;
            default: onehot_dig = 2'd0;
        endcase
    endfunction

    for (genvar g = 0; g < 2; g++) begin : u
        localparam int GAP  = (g == 0) ? 2 : 0;
        localparam int RESP = (g == 0) ? 1 : 3;
        localparam int L    = 4 * (1 + GAP) + 1 + RESP + 1;

        logic       rst = 1'b0;
        logic       start = 1'b0;
        logic       sweep = 1'b0;
        logic [7:0] code = 8'h00;
        logic       never_match = 1'b0;
        logic       busy, done, success, open, lock;
        logic [7:0] found;
        logic [3:0] keys;
        logic [7:0] ent;

        int   ops = 0;
        int   opens = 0;
        int   npress = 0;
        int   first = 0;
        int   last = 0;
        int   pressed[$];
        exp_t q[$];

        padlock_code_sender #(.GAP_CYCLES(GAP), .RESP_CYCLES(RESP)) dut (
            .clk        (clk),
            .reset      (rst),
            .start      (start),
            .sweep      (sweep),
            .code       (code),
            .busy       (busy),
            .done       (done),
            .success    (success),
            .found_code (found),
            .but_0      (keys[0]),
            .but_1      (keys[1]),
            .but_2      (keys[2]),
            .but_3      (keys[3]),
            .open       (open),
            .lock       (lock)
        );

        // Padlock model: secret 0x36; relocks on any press, lock valid the cycle after open.
        always @(posedge clk or negedge rst) begin
            if (!rst) begin
                ent  <= 8'h00;
                lock <= 1'b1;
            end else if (|keys) begin
                ent  <= {onehot_dig(keys), ent[7:2]};
                lock <= 1'b1;
            end else if (open) begin
                lock <= never_match || (ent != 8'h36);
            end
        end

        always @(negedge clk) begin
            if (!rst) begin
                opens  = 0;
                npress = 0;
            end else begin
                chk(g, "pins_exclusive", 32'(($countones(keys) <= 1) && !(open && (|keys))), 32'd1);
                if (|keys) begin
                    if (npress % 4 == 0) first = cyc;
                    else chk(g, "press_spacing", cyc - last, 1 + GAP);
                    last = cyc;
                    npress++;
                    pressed.push_back(int'(onehot_dig(keys)));
                end
                if (open) begin
                    opens++;
                    chk(g, "open_offset", cyc - first, 4 * (1 + GAP));
                end
                if (done) begin
                    if (q.size() == 0) begin
                        chk(g, "spurious_done", 32'd1, 32'd0);
                    end else begin
                        exp_t e;
                        e = q.pop_front();
                        chk(g, "success", success, e.success);
                        chk(g, "found_code", found, e.code);
                        chk(g, "open_count", opens, e.opens);
                        chk(g, "done_latency", cyc - first, L);
                        chk(g, "busy_low_at_done", busy, 0);
                    end
                    ops++;
                    opens  = 0;
                    npress = 0;
                end
            end
        end
    end

    function automatic logic done_of(input int inst);
        done_of = (inst == 0) ? u[0].done : u[1].done;
    endfunction

    task automatic start_a(input logic sw, input logic [7:0] c);
        @(posedge clk); #1;
        u[0].sweep = sw;
        u[0].code  = c;
        u[0].start = 1'b1;
        @(posedge clk); #1;
        u[0].start = 1'b0;
    endtask

    task automatic wait_done(input int inst, input int budget);
        int n = 0;
        while (done_of(inst) !== 1'b1 && n < budget) begin
            @(posedge clk); #1;
            n++;
        end
        chk(inst, "done_seen", done_of(inst), 1);
        @(negedge clk); #1;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        #12;
        chk(0, "rst_busy", u[0].busy, 0);
        chk(0, "rst_pins", {u[0].keys, u[0].open, u[0].done}, 0);
        chk(0, "rst_result", {u[0].success, u[0].found}, 0);
        chk(1, "rst_pins", {u[1].keys, u[1].open, u[1].done, u[1].busy}, 0);
        u[0].rst = 1'b1;
        u[1].rst = 1'b1;

        // Replay the right code: buttons 2,1,3,0.
        u[0].q.push_back(exp_t'{success: 1'b1, code: 8'h36, opens: 1});
        start_a(1'b0, 8'h36);
        chk(0, "busy_after_start", u[0].busy, 1);
        wait_done(0, 100);
        chk(0, "press_count", u[0].pressed.size(), 4);
        chk(0, "digit0", u[0].pressed[0], 2);
        chk(0, "digit1", u[0].pressed[1], 1);
        chk(0, "digit2", u[0].pressed[2], 3);
        chk(0, "digit3", u[0].pressed[3], 0);

        // Replay a wrong code.
        u[0].q.push_back(exp_t'{success: 1'b0, code: 8'h00, opens: 1});
        start_a(1'b0, 8'h00);
        wait_done(0, 100);
        chk(0, "lock_held", u[0].lock, 1);

        // Sweep stops at the first success.
        u[0].q.push_back(exp_t'{success: 1'b1, code: 8'h36, opens: 55});
        start_a(1'b1, 8'hA5);
        wait_done(0, 55 * 15 + 50);

        // Sweep exhaustion against a lock that never opens.
        u[0].never_match = 1'b1;
        u[0].q.push_back(exp_t'{success: 1'b0, code: 8'hFF, opens: 256});
        start_a(1'b1, 8'h00);
        wait_done(0, 256 * 15 + 50);
        u[0].never_match = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk(0, "single_done", u[0].ops, 4);

        // Reset during the gap after digit 2.
        start_a(1'b0, 8'h36);
        n = 0;
        while (u[0].npress != 3 && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        chk(0, "third_press_seen", u[0].npress, 3);
        chk(0, "busy_before_reset", u[0].busy, 1);
        u[0].rst = 1'b0;
        #1;
        chk(0, "async_rst_busy", u[0].busy, 0);
        chk(0, "async_rst_pins", {u[0].keys, u[0].open, u[0].done, u[0].success}, 0);
        @(posedge clk); #1;
        u[0].rst = 1'b1;
        u[0].q.push_back(exp_t'{success: 1'b1, code: 8'h36, opens: 1});
        start_a(1'b0, 8'h36);
        wait_done(0, 100);

        // No gaps, slow response, start held high across two operations.
        u[1].q.push_back(exp_t'{success: 1'b1, code: 8'h36, opens: 1});
        u[1].q.push_back(exp_t'{success: 1'b1, code: 8'h36, opens: 1});
        @(posedge clk); #1;
        u[1].code  = 8'h36;
        u[1].sweep = 1'b0;
        u[1].start = 1'b1;
        wait_done(1, 100);
        @(posedge clk); #1;
        chk(1, "idle_after_done", u[1].busy, 0);
        @(posedge clk); #1;
        chk(1, "restart_busy", u[1].busy, 1);
        u[1].start = 1'b0;
        wait_done(1, 100);
        chk(1, "ops", u[1].ops, 2);
        chk(0, "queue_drained", u[0].q.size(), 0);
        chk(1, "queue_drained", u[1].q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
